des_key_dispatcher: RTL and testbench

- Sits between the AXI4-Lite register bank of the DES cracker IP and the array of pipelined DES compare cores.
- Walks a software-programmed key range [first, last] and issues one 56-bit key per valid/ready handshake.
- Waits for the core pipeline to drain, then reports completion.
- Buffers matching keys reported by the cores in a small FIFO that software pops through the register bank.

---
 rtl/des_key_dispatcher.sv | 184 ++++++++++++++++++
 tb/tb_des_key_dispatcher.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_dispatcher.sv
// DES key dispatcher: walks [first, last] issuing one key per handshake, drains the core pipeline,
// and buffers reported matches in a FWFT FIFO. Optional stall counter under DISPATCH_STALL_CNT_EN.
module des_key_dispatcher #(
    parameter int KEY_W        = 56,
    parameter int PIPE_LATENCY = 16,
    parameter int MATCH_DEPTH  = 4
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [KEY_W-1:0] cfg_key_first,
    input  logic [KEY_W-1:0] cfg_key_last,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_data,
    input  logic             key_ready,
    input  logic             match_valid,
    input  logic [KEY_W-1:0] match_key,
    input  logic             match_pop,
    output logic [KEY_W-1:0] match_head,
    output logic             match_empty,
    output logic             match_ovf,
    output logic             busy,
    output logic             done,
    output logic             range_err,
`ifdef DISPATCH_STALL_CNT_EN
    output logic [31:0]      stall_cycles,
`endif
    output logic [KEY_W:0]   keys_issued,
    output logic [1:0]       dbg_state
);
    // Key stream handshake: a key transfers on a rising ACLK edge where key_valid && key_ready;
    // key_data is held stable while key_valid is high and key_ready is low.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DW = $clog2(PIPE_LATENCY + 1);
    localparam int AW = $clog2(MATCH_DEPTH);

    state_t           r_state;
    logic [KEY_W-1:0] r_cur;
    logic [KEY_W-1:0] r_last;
    logic [DW-1:0]    r_drain_cnt;
    logic [KEY_W:0]   r_keys_issued;
    logic             r_range_err;
    logic             r_ovf;
    logic [KEY_W-1:0] r_mem [MATCH_DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [KEY_W-1:0] r_head;

    logic             w_start;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push_req;
    logic             w_push;
    logic             w_drop;
    logic [AW:0]      w_rd_next;
    logic [AW:0]      w_wr_next;
    logic [KEY_W-1:0] w_head_next;

    assign w_start    = cfg_start && !cfg_abort && (r_state == S_IDLE || r_state == S_DONE);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop      = match_pop && !w_empty;
    assign w_push_req = match_valid && (r_state != S_IDLE);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    assign w_rd_next  = r_rd_ptr + {{AW{1'b0}}, w_pop};
    assign w_wr_next  = r_wr_ptr + {{AW{1'b0}}, w_push};

    // The new head is either the word being pushed this cycle (FIFO was empty at that slot)
    // or an already-stored entry.
    always_comb begin
        w_head_next = r_head;
        if (w_rd_next != w_wr_next) begin
            if (w_push && (w_rd_next[AW-1:0] == r_wr_ptr[AW-1:0]))
                w_head_next = match_key;
            else
                w_head_next = r_mem[w_rd_next[AW-1:0]];
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_push && !w_start)
            r_mem[r_wr_ptr[AW-1:0]] <= match_key;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
            r_ovf    <= 1'b0;
        end else if (w_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_head   <= w_head_next;
            if (w_drop)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state       <= S_IDLE;
            r_cur         <= '0;
            r_last        <= '0;
            r_drain_cnt   <= '0;
            r_keys_issued <= '0;
            r_range_err   <= 1'b0;
        end else if (cfg_abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (cfg_start) begin
                        r_cur         <= cfg_key_first;
                        r_last        <= cfg_key_last;
                        r_keys_issued <= '0;
                        r_range_err   <= (cfg_key_last < cfg_key_first);
                        r_state       <= (cfg_key_last < cfg_key_first) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (key_ready) begin
                        r_keys_issued <= r_keys_issued + 1'b1;
                        if (r_cur == r_last) begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= DW'(PIPE_LATENCY);
                        end else begin
                            r_cur <= r_cur + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == DW'(1))
                        r_state <= S_DONE;
                    else
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DISPATCH_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            r_stall_cycles <= '0;
        else if (w_start)
            r_stall_cycles <= '0;
        else if (r_state == S_RUN && !key_ready && r_stall_cycles != 32'hFFFF_FFFF)
            r_stall_cycles <= r_stall_cycles + 1'b1;
    end

    assign stall_cycles = r_stall_cycles;
`endif

    assign key_valid   = (r_state == S_RUN);
    assign key_data    = r_cur;
    assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);
    assign range_err   = r_range_err;
    assign keys_issued = r_keys_issued;
    assign match_head  = r_head;
    assign match_empty = w_empty;
    assign match_ovf   = r_ovf;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_des_key_dispatcher.sv
// Directed bench for des_key_dispatcher: table-driven range runs plus hand sequences for
// the match FIFO, abort and asynchronous reset.
module tb_des_key_dispatcher;
    localparam int KEY_W = 56;
    localparam int PL    = 4;

    logic             ACLK = 1'b0;
    logic             ARESET = 1'b1;
    logic             cfg_start = 1'b0;
    logic             cfg_abort = 1'b0;
    logic [KEY_W-1:0] cfg_key_first = '0;
    logic [KEY_W-1:0] cfg_key_last = '0;
    logic             key_valid;
    logic [KEY_W-1:0] key_data;
    logic             key_ready = 1'b0;
    logic             match_valid = 1'b0;
    logic [KEY_W-1:0] match_key = '0;
    logic             match_pop = 1'b0;
    logic [KEY_W-1:0] match_head;
    logic             match_empty;
    logic             match_ovf;
    logic             busy;
    logic             done;
    logic             range_err;
    logic [KEY_W:0]   keys_issued;
    logic [1:0]       dbg_state;
`ifdef DISPATCH_STALL_CNT_EN
    logic [31:0]      stall_cycles;
`endif

    int n_checks = 0;
    int n_err    = 0;

    des_key_dispatcher #(.KEY_W(KEY_W), .PIPE_LATENCY(PL), .MATCH_DEPTH(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_key_first(cfg_key_first), .cfg_key_last(cfg_key_last),
        .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
        .match_valid(match_valid), .match_key(match_key), .match_pop(match_pop),
        .match_head(match_head), .match_empty(match_empty), .match_ovf(match_ovf),
        .busy(busy), .done(done), .range_err(range_err),
`ifdef DISPATCH_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .keys_issued(keys_issued), .dbg_state(dbg_state)
    );

    always #5 ACLK = ~ACLK;

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_run(input logic [KEY_W-1:0] first, input logic [KEY_W-1:0] last);
        cfg_key_first = first;
        cfg_key_last  = last;
        cfg_start     = 1'b1;
        step();
        cfg_start     = 1'b0;
    endtask

    typedef struct {
        logic [KEY_W-1:0] first;
        logic [KEY_W-1:0] last;
        logic [3:0]       rdy;
        int               exp_keys;
        logic             exp_rerr;
        int               exp_run;
        int               exp_busy;
        int               exp_stall;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n_seen, n_run, busy_cnt, cyc;
        bit fin;
        logic [KEY_W-1:0] exp_key;

        vecs[0] = '{56'h10, 56'h13, 4'b1111, 4, 1'b0, 4, 8, 0};
        vecs[1] = '{56'h10, 56'h13, 4'b0101, 4, 1'b0, 7, 11, 3};
        vecs[2] = '{56'h20, 56'h1F, 4'b1111, 0, 1'b1, 0, 0, 0};
        vecs[3] = '{56'h05, 56'h05, 4'b1111, 1, 1'b0, 1, 5, 0};
        vecs[4] = '{56'hFF_FFFF_FFFF_FFFE, 56'hFF_FFFF_FFFF_FFFF, 4'b1111, 2, 1'b0, 2, 6, 0};
        vecs[5] = '{56'h30, 56'h32, 4'b0011, 3, 1'b0, 5, 9, 2};

        // Reset state
        #2;
        chk("rst_key_valid", 64'(key_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_match_empty", 64'(match_empty), 64'd1);
        chk("rst_keys_issued", 64'(keys_issued), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        step();
        ARESET = 1'b0;
        step();

        // Table-driven range runs
        for (int v = 0; v < 6; v++) begin
            start_run(vecs[v].first, vecs[v].last);
            n_seen = 0; n_run = 0; busy_cnt = 0; cyc = 0; fin = 1'b0;
            for (int t = 0; t < 300 && !fin; t++) begin
                if (done) begin
                    fin = 1'b1;
                end else begin
                    if (busy) busy_cnt++;
                    key_ready = 1'b0;
                    if (key_valid) begin
                        exp_key = vecs[v].first + KEY_W'(n_seen);
                        chk($sformatf("v%0d_key_data", v), 64'(key_data), 64'(exp_key));
                        n_run++;
                        key_ready = vecs[v].rdy[cyc % 4];
                        if (key_ready) n_seen++;
                        cyc++;
                    end
                    step();
                end
            end
            key_ready = 1'b0;
            if (!fin) chk($sformatf("v%0d_timeout", v), 64'd0, 64'd1);
            chk($sformatf("v%0d_keys_issued", v), 64'(keys_issued), 64'(vecs[v].exp_keys));
            chk($sformatf("v%0d_handshakes", v), 64'(n_seen), 64'(vecs[v].exp_keys));
            chk($sformatf("v%0d_run_cycles", v), 64'(n_run), 64'(vecs[v].exp_run));
            chk($sformatf("v%0d_busy_cycles", v), 64'(busy_cnt), 64'(vecs[v].exp_busy));
            chk($sformatf("v%0d_range_err", v), 64'(range_err), 64'(vecs[v].exp_rerr));
            chk($sformatf("v%0d_busy_at_done", v), 64'(busy), 64'd0);
`ifdef DISPATCH_STALL_CNT_EN
            chk($sformatf("v%0d_stall_cycles", v), 64'(stall_cycles), 64'(vecs[v].exp_stall));
`endif
            step();
        end

        // Match FIFO overflow and drain
        start_run(56'h10, 56'h13);
        key_ready = 1'b1;
        repeat (4) step();
        key_ready = 1'b0;
        chk("drain_key_valid", 64'(key_valid), 64'd0);
        chk("drain_busy", 64'(busy), 64'd1);
        match_valid = 1'b1;
        match_key = 56'hA1;
        step();
        chk("fwft_head", 64'(match_head), 64'hA1);
        chk("fwft_empty", 64'(match_empty), 64'd0);
        for (int k = 2; k <= 5; k++) begin
            match_key = KEY_W'(56'hA0 + k);
            step();
        end
        match_valid = 1'b0;
        step();
        chk("ovf_head", 64'(match_head), 64'hA1);
        chk("ovf_flag", 64'(match_ovf), 64'd1);
        match_pop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("pop%0d_head", k), 64'(match_head), 64'(56'hA1 + k));
            step();
        end
        chk("popped_empty", 64'(match_empty), 64'd1);
        step();
        match_pop = 1'b0;
        chk("pop_empty_ignored", 64'(match_empty), 64'd1);
        match_valid = 1'b1;
        match_key = 56'hB1;
        step();
        match_valid = 1'b0;
        chk("done_push_head", 64'(match_head), 64'hB1);
        chk("done_push_empty", 64'(match_empty), 64'd0);

        // Start clears the FIFO even with a same-cycle push
        match_valid = 1'b1;
        match_key = 56'hC1;
        start_run(56'h10, 56'h13);
        match_valid = 1'b0;
        chk("start_clear_empty", 64'(match_empty), 64'd1);
        chk("start_clear_ovf", 64'(match_ovf), 64'd0);
        match_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            match_key = KEY_W'(56'hD0 + k);
            step();
        end
        match_key = 56'hD5;
        match_pop = 1'b1;
        step();
        match_valid = 1'b0;
        chk("full_pushpop_ovf", 64'(match_ovf), 64'd0);
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("pp_pop%0d_head", k), 64'(match_head), 64'(56'hD0 + k));
            step();
        end
        match_pop = 1'b0;
        chk("pp_empty", 64'(match_empty), 64'd1);
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;

        // Abort mid-RUN after 10 handshakes
        start_run(56'h0, 56'hFF);
        key_ready = 1'b1;
        repeat (10) step();
        chk("abort_pre_key", 64'(key_data), 64'h0A);
        key_ready = 1'b0;
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        chk("abort_key_valid", 64'(key_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_keys_issued", 64'(keys_issued), 64'd10);
        cfg_abort = 1'b1;
        start_run(56'h0, 56'hFF);
        cfg_abort = 1'b0;
        chk("abort_over_start_busy", 64'(busy), 64'd0);
        chk("abort_over_start_keys", 64'(keys_issued), 64'd10);
        start_run(56'h0, 56'hFF);
        chk("restart_key_valid", 64'(key_valid), 64'd1);
        chk("restart_key_data", 64'(key_data), 64'h0);
        chk("restart_keys_issued", 64'(keys_issued), 64'd0);
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;

        // Asynchronous reset mid-DRAIN
        start_run(56'h10, 56'h13);
        key_ready = 1'b1;
        repeat (4) step();
        key_ready = 1'b0;
        match_valid = 1'b1;
        match_key = 56'hE1;
        step();
        match_valid = 1'b0;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        chk("pre_rst_empty", 64'(match_empty), 64'd0);
        #3;
        ARESET = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_match_empty", 64'(match_empty), 64'd1);
        chk("arst_match_head", 64'(match_head), 64'd0);
        chk("arst_keys_issued", 64'(keys_issued), 64'd0);
        chk("arst_key_data", 64'(key_data), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        step();
        ARESET = 1'b0;
        match_valid = 1'b1;
        match_key = 56'hF1;
        step();
        match_valid = 1'b0;
        step();
        chk("idle_match_ignored", 64'(match_empty), 64'd1);
        chk("idle_state", 64'(dbg_state), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
